// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: UART RX frame FSM (start/8 data/opt parity/stop); UART_RX_MAJORITY_EN selects 2-of-3 mid-bit voting
module uart_rx_frame_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_in,
  input  logic              par_en,
  input  logic              par_typ,
  input  logic [5:0]        prescale,
  input  logic [5:0]        edge_cnt,
  input  logic [3:0]        bit_cnt,
  output logic              cnt_enable,
  output logic [DATA_W-1:0] p_data,
  output logic              data_valid,
  output logic              par_err,
  output logic              stp_err
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, next;
  logic [DATA_W-1:0] shreg;
  logic par_en_l, par_typ_l, par_fail, sampled, s_mid, vote, eob, smp;
  logic [5:0] s_pt;
  assign s_pt = (prescale >> 1) - 6'd1;
  assign eob = edge_cnt == prescale - 6'd1;
  assign smp = edge_cnt == s_pt + 6'd1;
  assign cnt_enable = state != IDLE;
`ifdef UART_RX_MAJORITY_EN
  logic s_early;
  always_ff @(posedge clk) begin
    if (reset) begin
      s_early <= 1'b0;
      s_mid <= 1'b0;
    end else begin
      if (edge_cnt == s_pt - 6'd1) s_early <= rx_in;
      if (edge_cnt == s_pt) s_mid <= rx_in;
    end
  end
  assign vote = (s_early & s_mid) | (s_early & rx_in) | (s_mid & rx_in);
`else
  always_ff @(posedge clk) begin
    if (reset) s_mid <= 1'b0;
    else if (edge_cnt == s_pt) s_mid <= rx_in;
  end
  assign vote = s_mid;
`endif
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = rx_in ? IDLE : START;
      START:   next = eob ? (sampled ? IDLE : DATA) : START;
      DATA:    next = (eob && bit_cnt == 4'd8) ? (par_en_l ? PARITY : STOP) : DATA;
      PARITY:  next = eob ? STOP : PARITY;
      STOP:    next = eob ? IDLE : STOP;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      p_data <= '0;
      data_valid <= 1'b0;
      par_err <= 1'b0;
      stp_err <= 1'b0;
      par_en_l <= 1'b0;
      par_typ_l <= 1'b0;
      par_fail <= 1'b0;
      sampled <= 1'b0;
    end else begin
      state <= next;
      data_valid <= 1'b0;
      par_err <= 1'b0;
      stp_err <= 1'b0;
      if (smp) sampled <= vote;
      if (state == IDLE && !rx_in) begin
        par_en_l <= par_en;
        par_typ_l <= par_typ;
        par_fail <= 1'b0;
      end
      if (eob && state == DATA) shreg[bit_cnt[2:0] - 3'd1] <= sampled;
      if (eob && state == PARITY) par_fail <= sampled != (^shreg ^ par_typ_l);
      // a good frame needs a high stop bit and no parity failure
      if (eob && state == STOP) begin
        stp_err <= ~sampled;
        par_err <= par_fail;
        data_valid <= sampled & ~par_fail;
        if (sampled && !par_fail) p_data <= shreg;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed frames with a scoreboard monitor; models the external edge/bit counter
module tb_uart_rx_frame_ctrl;
  typedef struct packed {logic dv; logic pe; logic se; logic [7:0] pd;} exp_t;
  logic clk = 0, reset = 1, rx_in = 1, par_en = 0, par_typ = 0;
  logic [5:0] prescale = 6'd8, edge_cnt;
  logic [3:0] bit_cnt;
  logic cnt_enable, data_valid, par_err, stp_err;
  logic [7:0] p_data;
  exp_t sb[$];
  exp_t got, want;
  int n_tests = 0, n_fail = 0;

  uart_rx_frame_ctrl dut (
    .clk(clk), .reset(reset), .rx_in(rx_in), .par_en(par_en), .par_typ(par_typ),
    .prescale(prescale), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .cnt_enable(cnt_enable),
    .p_data(p_data), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (!cnt_enable) begin
      edge_cnt <= '0;
      bit_cnt <= '0;
    end else if (edge_cnt == prescale - 6'd1) begin
      edge_cnt <= '0;
      bit_cnt <= bit_cnt + 4'd1;
    end else edge_cnt <= edge_cnt + 6'd1;
  end

  always @(negedge clk) begin
    if (!reset && (data_valid || par_err || stp_err)) begin
      got = {data_valid, par_err, stp_err, p_data};
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe got dv=%b pe=%b se=%b pd=%h", got.dv, got.pe, got.se, got.pd);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL frame got dv=%b pe=%b se=%b pd=%h want dv=%b pe=%b se=%b pd=%h",
                   got.dv, got.pe, got.se, got.pd, want.dv, want.pe, want.se, want.pd);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, act, req);
    end
  endtask

  task automatic push(input logic dv, input logic pe, input logic se, input logic [7:0] pd);
    sb.push_back({dv, pe, se, pd});
  endtask

  task automatic drive_bit(input logic b, input bit glitch, input bit abrt, inout bit quit);
    for (int i = 0; i < int'(prescale) && !quit; i++) begin
      rx_in = b ^ (glitch && bit_cnt == 4'd4 && edge_cnt == 6'd7);
      if (abrt && bit_cnt == 4'd5 && edge_cnt == 6'd2) begin
        reset = 1;
        rx_in = 1;
        quit = 1;
      end
      @(negedge clk);
      reset = 0;
    end
  endtask

  task automatic send(input logic [7:0] d, input bit pen, input bit ptyp, input logic pbit,
                      input logic sbit, input bit glitch, input bit abrt);
    bit q = 0;
    par_en = pen;
    par_typ = ptyp;
    drive_bit(1'b0, glitch, abrt, q);
    for (int k = 0; k < 8; k++) drive_bit(d[k], glitch, abrt, q);
    if (pen) drive_bit(pbit, glitch, abrt, q);
    drive_bit(sbit, glitch, abrt, q);
    rx_in = 1;
  endtask

  task automatic idle(input int n);
    rx_in = 1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    check("reset_cnt_enable", 32'(cnt_enable), 32'd0);
    check("reset_p_data", 32'(p_data), 32'h00);
    check("reset_strobes", 32'({data_valid, par_err, stp_err}), 32'd0);
    idle(4);
    // prescale 8, no parity
    prescale = 6'd8;
    push(1, 0, 0, 8'hA5);
    send(8'hA5, 0, 0, 0, 1, 0, 0);
    idle(20);
    // prescale 16, even parity good then bad
    prescale = 6'd16;
    push(1, 0, 0, 8'h3C);
    send(8'h3C, 1, 0, 0, 1, 0, 0);
    idle(30);
    push(0, 1, 0, 8'h3C);
    send(8'h3C, 1, 0, 1, 1, 0, 0);
    idle(30);
    // odd parity good, then parity and stop errors together
    push(1, 0, 0, 8'h07);
    send(8'h07, 1, 1, 0, 1, 0, 0);
    idle(30);
    push(0, 1, 1, 8'h07);
    send(8'h07, 1, 0, 0, 0, 0, 0);
    idle(30);
    // prescale 32, stop error then good frame
    prescale = 6'd32;
    push(0, 0, 1, 8'h07);
    send(8'h81, 0, 0, 0, 0, 0, 0);
    idle(60);
    push(1, 0, 0, 8'h7E);
    send(8'h7E, 0, 0, 0, 1, 0, 0);
    idle(60);
    // start glitch of 2 clk aborts
    prescale = 6'd8;
    rx_in = 0;
    repeat (2) @(negedge clk);
    rx_in = 1;
    check("glitch_cnt_enable_up", 32'(cnt_enable), 32'd1);
    idle(15);
    check("glitch_cnt_enable_down", 32'(cnt_enable), 32'd0);
    check("glitch_p_data_held", 32'(p_data), 32'h7E);
    // back-to-back frames
    push(1, 0, 0, 8'h12);
    push(1, 0, 0, 8'h34);
    send(8'h12, 0, 0, 0, 1, 0, 0);
    send(8'h34, 0, 0, 0, 1, 0, 0);
    idle(20);
    // one-cycle inverted glitch at edge 7 of data bit 3
    prescale = 6'd16;
`ifdef UART_RX_MAJORITY_EN
    push(1, 0, 0, 8'h5A);
`else
    push(1, 0, 0, 8'h52);
`endif
    send(8'h5A, 0, 0, 0, 1, 1, 0);
    idle(30);
    // reset mid-frame at bit_cnt 5
    prescale = 6'd8;
    send(8'hF0, 0, 0, 0, 1, 0, 1);
    check("midreset_cnt_enable", 32'(cnt_enable), 32'd0);
    check("midreset_p_data", 32'(p_data), 32'h00);
    check("midreset_strobes", 32'({data_valid, par_err, stp_err}), 32'd0);
    idle(10);
    push(1, 0, 0, 8'h55);
    send(8'h55, 0, 0, 0, 1, 0, 0);
    idle(20);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
